// File: rtl/teng_tx_scramble_gbx.sv
// teng_tx_scramble_gbx
// TX path between the 64b/66b encoder and a GTX in external-gearbox mode.
// Each 32-bit half-block is scrambled with the self-synchronous x^58+x^39+1
// polynomial. The 2-bit sync header passes through unscrambled. The block
// generates the TXSEQUENCE count and stalls the encoder for the gearbox
// pause slot.

module teng_tx_scramble_gbx #(
    parameter int          SEQ_MAX  = 32,
    parameter logic [57:0] SCR_INIT = {58{1'b1}}
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] encode_data_i,
    input  logic [1:0]  encode_head_i,
    input  logic        encode_data_vld_i,
    output logic        encode_rdy_o,
    input  logic        scr_bypass_i,
    output logic [31:0] gt_txdata_o,
    output logic [1:0]  gt_txheader_o,
    output logic [6:0]  gt_txsequence_o,
    output logic        err_underflow_o
);

    localparam logic [5:0] SEQ_LAST = 6'(SEQ_MAX);

    // ST_HOLD is the single cycle after reset release: nothing is accepted
    // and phase/seq do not move. This makes the first accepted word land
    // on phase 0, seq 0.
    typedef enum logic [1:0] {
        ST_HOLD,
        ST_FIRST,
        ST_SECOND
    } phase_state_t;

    phase_state_t state;
    phase_state_t state_next;
    logic [5:0]   seq;
    logic [57:0]  scr_state;
    logic [57:0]  scr_next;
    logic [57:0]  scr_shift;
    logic [31:0]  scr_word;
    logic         running;
    logic         accept;

    assign running      = (state != ST_HOLD);
    assign encode_rdy_o = running & (seq != SEQ_LAST);
    assign accept       = encode_data_vld_i & encode_rdy_o;

    // Phase state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Phase alternates first/second half every cycle once running.
    always_comb begin
        state_next = ST_HOLD;
        case (state)
            ST_HOLD:   state_next = ST_FIRST;
            ST_FIRST:  state_next = ST_SECOND;
            ST_SECOND: state_next = ST_FIRST;
            default:   state_next = ST_HOLD;
        endcase
    end

    // Gearbox sequence counter: one value per 66b block, wraps after the pause slot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seq <= '0;
        end else if (state == ST_SECOND) begin
            seq <= (seq == SEQ_LAST) ? 6'd0 : seq + 6'd1;
        end
    end

    // Bit-serial scrambler unrolled over the word, LSB first; bypass feeds raw data into the history.
    always_comb begin
        scr_shift = scr_state;
        scr_word  = '0;
        for (int i = 0; i < 32; i++) begin
            scr_word[i] = scr_bypass_i ? encode_data_i[i]
                                       : (encode_data_i[i] ^ scr_shift[38] ^ scr_shift[57]);
            scr_shift   = {scr_shift[56:0], scr_word[i]};
        end
        scr_next = scr_shift;
    end

    // Scrambler history advances only on accepted words.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scr_state <= SCR_INIT;
        end else if (accept) begin
            scr_state <= scr_next;
        end
    end

    // Output register: data/header hold unless a word is accepted; sequence tracks seq each running cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gt_txdata_o     <= '0;
            gt_txheader_o   <= '0;
            gt_txsequence_o <= '0;
            err_underflow_o <= 1'b0;
        end else begin
            err_underflow_o <= encode_rdy_o & ~encode_data_vld_i;
            if (running) begin
                gt_txsequence_o <= {1'b0, seq};
            end
            if (accept) begin
                gt_txdata_o <= scr_word;
                if (state == ST_FIRST) begin
                    gt_txheader_o <= encode_head_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_teng_tx_scramble_gbx.sv
// tb_teng_tx_scramble_gbx
// Directed bench for the TX scrambler/gearbox sequencer. Each task resets the
// DUT where needed and checks outputs 1 time unit after the rising edge.

module tb_teng_tx_scramble_gbx;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] encode_data_i = '0;
    logic [1:0]  encode_head_i = '0;
    logic        encode_data_vld_i = 1'b0;
    logic        encode_rdy_o;
    logic        scr_bypass_i = 1'b0;
    logic [31:0] gt_txdata_o;
    logic [1:0]  gt_txheader_o;
    logic [6:0]  gt_txsequence_o;
    logic        err_underflow_o;

    int checks = 0;
    int failures = 0;

    logic [57:0] model_st;
    logic [57:0] desc_st;

    teng_tx_scramble_gbx #(
        .SEQ_MAX  (32),
        .SCR_INIT ({58{1'b1}})
    ) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .encode_data_i     (encode_data_i),
        .encode_head_i     (encode_head_i),
        .encode_data_vld_i (encode_data_vld_i),
        .encode_rdy_o      (encode_rdy_o),
        .scr_bypass_i      (scr_bypass_i),
        .gt_txdata_o       (gt_txdata_o),
        .gt_txheader_o     (gt_txheader_o),
        .gt_txsequence_o   (gt_txsequence_o),
        .err_underflow_o   (err_underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Golden x^58+x^39+1 scrambler: out[n] = d[n] ^ out[n-39] ^ out[n-58].
    task automatic model_word(input logic [31:0] d, input logic byp, output logic [31:0] o);
        logic b;
        o = '0;
        for (int i = 0; i < 32; i++) begin
            b = d[i] ^ model_st[38] ^ model_st[57];
            o[i] = byp ? d[i] : b;
            model_st = {model_st[56:0], o[i]};
        end
    endtask

    // Software descrambler: recovers data from the scrambled stream history.
    task automatic descramble_word(input logic [31:0] s, output logic [31:0] d);
        d = '0;
        for (int i = 0; i < 32; i++) begin
            d[i] = s[i] ^ desc_st[38] ^ desc_st[57];
            desc_st = {desc_st[56:0], s[i]};
        end
    endtask

    // Reset, release on a falling edge, then one edge to leave the hold cycle.
    task automatic do_reset();
        encode_data_vld_i = 1'b0;
        encode_data_i     = '0;
        encode_head_i     = '0;
        scr_bypass_i      = 1'b0;
        rst_n_i           = 1'b0;
        #12;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        model_st = {58{1'b1}};
        desc_st  = {58{1'b1}};
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        #3;
        checks++;
        if (gt_txdata_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_txdata: got %h expected %h", gt_txdata_o, 32'h0);
        end
        checks++;
        if (gt_txheader_o !== 2'b00 || gt_txsequence_o !== 7'd0) begin
            failures++;
            $display("[TB] FAIL reset_hdr_seq: got hdr=%b seq=%0d expected hdr=00 seq=0", gt_txheader_o, gt_txsequence_o);
        end
        checks++;
        if (encode_rdy_o !== 1'b0 || err_underflow_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_rdy_err: got rdy=%b err=%b expected 0 0", encode_rdy_o, err_underflow_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        checks++;
        if (encode_rdy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rdy_before_clock: got %b expected 0", encode_rdy_o);
        end
        tick();
        checks++;
        if (encode_rdy_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rdy_first_clock: got %b expected 1", encode_rdy_o);
        end
    endtask

    task automatic test_sequence();
        int   exp_seq;
        logic exp_rdy;
        do_reset();
        encode_data_vld_i = 1'b1;
        checks++;
        if (gt_txsequence_o !== 7'd0) begin
            failures++;
            $display("[TB] FAIL seq_start: got %0d expected 0", gt_txsequence_o);
        end
        for (int k = 0; k < 70; k++) begin
            exp_seq = (k / 2) % 33;
            exp_rdy = (exp_seq != 32);
            checks++;
            if (encode_rdy_o !== exp_rdy) begin
                failures++;
                $display("[TB] FAIL seq_rdy cycle %0d: got %b expected %b", k, encode_rdy_o, exp_rdy);
            end
            tick();
            checks++;
            if (gt_txsequence_o !== 7'(exp_seq) || err_underflow_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL seq_value cycle %0d: got seq=%0d err=%b expected seq=%0d err=0",
                         k, gt_txsequence_o, err_underflow_o, exp_seq);
            end
        end
    endtask

    task automatic test_bypass();
        do_reset();
        scr_bypass_i      = 1'b1;
        encode_data_vld_i = 1'b1;
        encode_head_i     = 2'b01;
        encode_data_i     = 32'hA5A5A5A5;
        tick();
        checks++;
        if (gt_txdata_o !== 32'hA5A5A5A5 || gt_txheader_o !== 2'b01) begin
            failures++;
            $display("[TB] FAIL bypass_first: got %h/%b expected a5a5a5a5/01", gt_txdata_o, gt_txheader_o);
        end
        encode_head_i = 2'b10;
        encode_data_i = 32'h5A5A5A5A;
        tick();
        checks++;
        if (gt_txdata_o !== 32'h5A5A5A5A || gt_txheader_o !== 2'b01) begin
            failures++;
            $display("[TB] FAIL bypass_second: got %h/%b expected 5a5a5a5a/01", gt_txdata_o, gt_txheader_o);
        end
        encode_head_i = 2'b11;
        encode_data_i = 32'h0F0F0F0F;
        tick();
        checks++;
        if (gt_txdata_o !== 32'h0F0F0F0F || gt_txheader_o !== 2'b11) begin
            failures++;
            $display("[TB] FAIL bypass_next_block: got %h/%b expected 0f0f0f0f/11", gt_txdata_o, gt_txheader_o);
        end
    endtask

    task automatic test_scramble();
        logic [31:0] exp_w;
        logic [31:0] rec;
        do_reset();
        encode_data_vld_i = 1'b1;
        encode_data_i     = '0;
        for (int w = 0; w < 64; w++) begin
            tick();
            model_word(32'h0, 1'b0, exp_w);
            checks++;
            if (gt_txdata_o !== exp_w) begin
                failures++;
                $display("[TB] FAIL scramble_word %0d: got %h expected %h", w, gt_txdata_o, exp_w);
            end
            descramble_word(gt_txdata_o, rec);
            checks++;
            if (rec !== 32'h0) begin
                failures++;
                $display("[TB] FAIL descramble_word %0d: got %h expected %h", w, rec, 32'h0);
            end
            if (w == 1) begin
                checks++;
                if (gt_txdata_o !== 32'h03FFFF80) begin
                    failures++;
                    $display("[TB] FAIL scramble_hand_w1: got %h expected %h", gt_txdata_o, 32'h03FFFF80);
                end
            end
        end
    endtask

    task automatic test_underflow();
        logic [31:0] exp_w;
        logic [31:0] last_w;
        do_reset();
        encode_data_vld_i = 1'b1;
        last_w = '0;
        for (int k = 0; k < 11; k++) begin
            encode_data_i = 32'h11110000 + k;
            tick();
            model_word(32'h11110000 + k, 1'b0, last_w);
        end
        checks++;
        if (gt_txdata_o !== last_w) begin
            failures++;
            $display("[TB] FAIL underflow_pre: got %h expected %h", gt_txdata_o, last_w);
        end
        encode_data_vld_i = 1'b0;
        encode_data_i     = 32'hDEADBEEF;
        tick();
        checks++;
        if (err_underflow_o !== 1'b1 || gt_txdata_o !== last_w || gt_txsequence_o !== 7'd5) begin
            failures++;
            $display("[TB] FAIL underflow_gap: got err=%b data=%h seq=%0d expected err=1 data=%h seq=5",
                     err_underflow_o, gt_txdata_o, gt_txsequence_o, last_w);
        end
        encode_data_vld_i = 1'b1;
        encode_data_i     = 32'hCAFE0000;
        tick();
        model_word(32'hCAFE0000, 1'b0, exp_w);
        checks++;
        if (err_underflow_o !== 1'b0 || gt_txdata_o !== exp_w || gt_txsequence_o !== 7'd6) begin
            failures++;
            $display("[TB] FAIL underflow_resume: got err=%b data=%h seq=%0d expected err=0 data=%h seq=6",
                     err_underflow_o, gt_txdata_o, gt_txsequence_o, exp_w);
        end
    endtask

    task automatic test_reset_midblock();
        do_reset();
        scr_bypass_i      = 1'b1;
        encode_head_i     = 2'b10;
        encode_data_vld_i = 1'b1;
        for (int k = 0; k < 35; k++) begin
            encode_data_i = 32'h12345678 ^ k;
            tick();
        end
        checks++;
        if (gt_txdata_o !== (32'h12345678 ^ 32'd34) || gt_txsequence_o !== 7'd17) begin
            failures++;
            $display("[TB] FAIL midreset_pre: got %h seq=%0d expected %h seq=17",
                     gt_txdata_o, gt_txsequence_o, 32'h12345678 ^ 32'd34);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (gt_txdata_o !== 32'h0 || gt_txheader_o !== 2'b00 || gt_txsequence_o !== 7'd0 ||
            encode_rdy_o !== 1'b0 || err_underflow_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_async: got data=%h hdr=%b seq=%0d rdy=%b err=%b expected all 0",
                     gt_txdata_o, gt_txheader_o, gt_txsequence_o, encode_rdy_o, err_underflow_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        scr_bypass_i  = 1'b0;
        encode_data_i = '0;
        encode_head_i = 2'b01;
        tick();
        checks++;
        if (gt_txdata_o !== 32'h0 || gt_txsequence_o !== 7'd0 || gt_txheader_o !== 2'b01) begin
            failures++;
            $display("[TB] FAIL midreset_restart0: got data=%h seq=%0d hdr=%b expected 00000000 0 01",
                     gt_txdata_o, gt_txsequence_o, gt_txheader_o);
        end
        tick();
        checks++;
        if (gt_txdata_o !== 32'h03FFFF80) begin
            failures++;
            $display("[TB] FAIL midreset_restart1: got %h expected %h", gt_txdata_o, 32'h03FFFF80);
        end
    endtask

    task automatic test_pause();
        logic [31:0] exp_w;
        logic [31:0] last_w;
        do_reset();
        encode_data_vld_i = 1'b1;
        encode_head_i     = 2'b10;
        last_w = '0;
        for (int w = 0; w < 64; w++) begin
            encode_data_i = 32'h01010101 * w;
            tick();
            model_word(32'h01010101 * w, 1'b0, last_w);
        end
        encode_data_i = 32'hDEADBEEF;
        encode_head_i = 2'b01;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (encode_rdy_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL pause_rdy %0d: got %b expected 0", p, encode_rdy_o);
            end
            tick();
            checks++;
            if (gt_txdata_o !== last_w || gt_txheader_o !== 2'b10 || err_underflow_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL pause_hold %0d: got data=%h hdr=%b err=%b expected data=%h hdr=10 err=0",
                         p, gt_txdata_o, gt_txheader_o, err_underflow_o, last_w);
            end
        end
        for (int w = 0; w < 2; w++) begin
            encode_data_i = 32'h00FF00FF << w;
            tick();
            model_word(32'h00FF00FF << w, 1'b0, exp_w);
            checks++;
            if (gt_txdata_o !== exp_w) begin
                failures++;
                $display("[TB] FAIL pause_after %0d: got %h expected %h", w, gt_txdata_o, exp_w);
            end
        end
    endtask

    initial begin
        model_st = {58{1'b1}};
        desc_st  = {58{1'b1}};
        test_reset();
        test_sequence();
        test_bypass();
        test_scramble();
        test_underflow();
        test_reset_midblock();
        test_pause();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
